// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink blocks.
// State encoding plus the half-period divider length.
package led_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } state_t;

  function automatic int half_period(
    input int clk_freq,
    input int blink_freq
  );
    return clk_freq / (2 * blink_freq);
  endfunction

endpackage

// File: rtl/led_blink_arbiter_if.sv
// Request/grant bundle between status sources and the LED arbiter.
// master = requester side, slave = arbiter side.
interface led_blink_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] cnt;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [OW-1:0]            owner;
  logic                     led;

  modport master (
    output req, cnt,
    input  ack, done, busy, owner, led
  );

  modport slave (
    input  req, cnt,
    output ack, done, busy, owner, led
  );

endinterface

// File: rtl/led_tick_gen.sv
// Half-period tick divider, restartable via clear.
// pre_tick marks the cycle before tick (assumes P >= 2).
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BLINK_FREQ = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int P = half_period(CLK_FREQ, BLINK_FREQ);
  localparam int W = (P > 1) ? $clog2(P) : 1;

  logic [W-1:0] count;

  assign tick     = (count == W'(P - 1));
  assign pre_tick = (count == W'(P - 2));

  // Count 0..P-1, wrap on tick, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of one status LED; plays N-blink bursts.
// The final phase retires on pre_tick so done lands with IDLE.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BLINK_FREQ = 1,
  parameter int NUM_REQ    = 3,
  parameter int CNT_W      = 4,
  parameter int GAP_TICKS  = 2
) (
  input logic clk,
  input logic rst_n,
  led_blink_arbiter_if.slave bus
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_t             state, state_n;
  logic               led_q, led_n;
  logic [NUM_REQ-1:0] ack_q, ack_n;
  logic [NUM_REQ-1:0] done_q, done_n;
  logic [OW-1:0]      owner_q, owner_n;
  logic [OW-1:0]      last_q, last_n;
  logic [CNT_W-1:0]   rem_q, rem_n;
  logic [GW-1:0]      gap_q, gap_n;

  logic               found;
  logic [OW-1:0]      pick;
  logic [CNT_W-1:0]   sel_cnt;
  logic               grant;
  logic               tick;
  logic               pre_tick;

  led_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BLINK_FREQ(BLINK_FREQ)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Round-robin pick: first set req after last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req[(int'(last_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = OW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  assign sel_cnt = bus.cnt[int'(pick)*CNT_W +: CNT_W];

  // Next-state and registered outputs of the burst sequencer.
  always_comb begin
    state_n = state;
    led_n   = led_q;
    ack_n   = '0;
    done_n  = '0;
    owner_n = owner_q;
    last_n  = last_q;
    rem_n   = rem_q;
    gap_n   = gap_q;
    grant   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          grant   = 1'b1;
          owner_n = pick;
          last_n  = pick;
          rem_n   = sel_cnt;
          gap_n   = '0;
          ack_n   = NUM_REQ'(1) << pick;
          if (sel_cnt != '0) begin
            state_n = S_ON;
            led_n   = 1'b1;
          end else if (GAP_TICKS == 0) begin
            done_n = NUM_REQ'(1) << pick;
          end else begin
            state_n = S_GAP;
          end
        end
      end
      S_ON: begin
        if (tick) begin
          state_n = S_OFF;
          led_n   = 1'b0;
          rem_n   = rem_q - 1'b1;
        end
      end
      S_OFF: begin
        if (rem_q != '0) begin
          if (tick) begin
            state_n = S_ON;
            led_n   = 1'b1;
          end
        end else if (GAP_TICKS == 0) begin
          if (pre_tick) begin
            state_n = S_IDLE;
            done_n  = NUM_REQ'(1) << owner_q;
          end
        end else if (tick) begin
          state_n = S_GAP;
          gap_n   = '0;
        end
      end
      S_GAP: begin
        if (pre_tick && gap_q == GW'(GAP_TICKS - 1)) begin
          state_n = S_IDLE;
          done_n  = NUM_REQ'(1) << owner_q;
        end else if (tick) begin
          gap_n = gap_q + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Sequencer and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      led_q   <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state   <= state_n;
      led_q   <= led_n;
      ack_q   <= ack_n;
      done_q  <= done_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      rem_q   <= rem_n;
      gap_q   <= gap_n;
    end
  end

  assign bus.led   = led_q;
  assign bus.ack   = ack_q;
  assign bus.done  = done_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Scoreboard bench for led_blink_arbiter, P=4, 3 requesters, gap 2.
// Stimulus queues expected ack/done events; a negedge monitor checks.
module tb_led_blink_arbiter;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_blink_arbiter_if #(.NUM_REQ(3), .CNT_W(4)) bus ();

  led_blink_arbiter #(
    .CLK_FREQ  (8),
    .BLINK_FREQ(1),
    .NUM_REQ   (3),
    .CNT_W     (4),
    .GAP_TICKS (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int idx;
    int delta;
    int n;
  } ev_t;

  ev_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acks = 0;
  int dones = 0;
  int last_evt = 0;
  int a_cyc = 0;
  int n_cur = 0;
  bit in_burst = 1'b0;
  bit prev_busy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input int idx, input int delta, input int n);
    ev_t e;
    e.is_done = d;
    e.idx = idx;
    e.delta = delta;
    e.n = n;
    sb.push_back(e);
  endtask

  task automatic take(input bit is_done, input logic [2:0] vec);
    ev_t e;
    if (sb.size() == 0) begin
      check(is_done ? "unexpected_done" : "unexpected_ack", int'(vec), 0);
    end else begin
      e = sb.pop_front();
      check("evt_kind", int'(is_done), int'(e.is_done));
      check(is_done ? "done_vec" : "ack_vec", int'(vec), 1 << e.idx);
      check("owner", int'(bus.owner), e.idx);
      check("busy", int'(bus.busy), is_done ? 0 : 1);
      if (is_done) check("busy_before_done", int'(prev_busy), 1);
      if (e.delta >= 0) check("evt_delay", cyc - last_evt, e.delta);
      if (!is_done) begin
        in_burst = 1'b1;
        a_cyc = cyc;
        n_cur = e.n;
      end
    end
    last_evt = cyc;
  endtask

  // Monitor: consumes scoreboard events and checks the LED waveform.
  always @(negedge clk) begin
    int k;
    bit led_exp;
    if (!rst_n) begin
      in_burst = 1'b0;
      check("reset_outs",
            int'({bus.led, bus.busy, bus.ack, bus.done}), 0);
    end else begin
      if (bus.ack != '0) begin
        acks++;
        take(1'b0, bus.ack);
      end
      k = cyc - a_cyc;
      led_exp = in_burst && (k < 2 * n_cur * P) && ((k / P) % 2 == 0);
      check("led", int'(bus.led), int'(led_exp));
      if (bus.done != '0) begin
        dones++;
        take(1'b1, bus.done);
        in_burst = 1'b0;
      end
    end
    prev_busy = bus.busy;
  end

  task automatic set_cnt(input int i, input int v);
    bus.cnt[i*4 +: 4] = 4'(v);
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (acks < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (acks < target) check("ack_timeout", acks, target);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.req = '0;
    bus.cnt = '0;
    repeat (3) @(negedge clk);
    check("reset_owner", int'(bus.owner), 0);
    check("reset_led", int'(bus.led), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, two blinks.
    push(1'b0, 0, -1, 2);
    push(1'b1, 0, (2*2 + 2)*P - 1, 0);
    set_cnt(0, 2);
    bus.req = 3'b001;
    wait_acks(acks + 1);
    bus.req = '0;
    wait_drain();

    // All three requesting: 0,1,2,0 back to back.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(1'b0, i % 3, (i == 0) ? -1 : 1, 1);
      push(1'b1, i % 3, (2 + 2)*P - 1, 0);
    end
    set_cnt(0, 1);
    set_cnt(1, 1);
    set_cnt(2, 1);
    bus.req = 3'b111;
    wait_acks(acks + 4);
    @(negedge clk);
    bus.req = '0;
    wait_drain();

    // Zero-count burst: gap only.
    push(1'b0, 1, -1, 0);
    push(1'b1, 1, 2*P - 1, 0);
    set_cnt(1, 0);
    bus.req = 3'b010;
    wait_acks(acks + 1);
    bus.req = '0;
    wait_drain();

    // req and cnt changed after grant have no effect.
    push(1'b0, 0, -1, 1);
    push(1'b1, 0, (2 + 2)*P - 1, 0);
    set_cnt(0, 1);
    bus.req = 3'b001;
    wait_acks(acks + 1);
    repeat (2) @(negedge clk);
    bus.req = '0;
    set_cnt(0, 7);
    wait_drain();

    // Async reset inside an ON phase.
    push(1'b0, 0, -1, 3);
    push(1'b1, 0, (2*3 + 2)*P - 1, 0);
    set_cnt(0, 3);
    bus.req = 3'b001;
    wait_acks(acks + 1);
    bus.req = '0;
    @(posedge clk);
    #2;
    check("led_on_before_rst", int'(bus.led), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("led_async_rst", int'(bus.led), 0);
    check("busy_async_rst", int'(bus.busy), 0);
    check("owner_async_rst", int'(bus.owner), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // After reset requester 0 wins over 1 again.
    push(1'b0, 0, -1, 1);
    push(1'b1, 0, (2 + 2)*P - 1, 0);
    push(1'b0, 1, 1, 1);
    push(1'b1, 1, (2 + 2)*P - 1, 0);
    set_cnt(0, 1);
    set_cnt(1, 1);
    bus.req = 3'b011;
    wait_acks(acks + 2);
    @(negedge clk);
    bus.req = '0;
    wait_drain();

    check("total_dones", dones, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares one status LED between `NUM_REQ` requesters, each asking for a burst of N blinks. Round-robin arbitration grants the LED to one requester at a time. The block then sequences the burst with an internal half-period tick divider, inserts a dark gap, and signals completion. It sits between firmware/status sources and the board LED pin, replacing free-running blinkers.

## Interface
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BLINK_FREQ`, 1: blink rate in Hz. One half-period is P = CLK_FREQ/(2*BLINK_FREQ) cycles.
- `NUM_REQ`, 3: number of requesters, minimum 2.
- `CNT_W`, 4: width of each blink-count field.
- `GAP_TICKS`, 2: dark half-periods after a burst before the LED is released. 0 is allowed.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: level request, one bit per requester.
- `cnt`  in  NUM_REQ*CNT_W: blink count; requester i uses bits [i*CNT_W +: CNT_W].
- `ack`  out  NUM_REQ: one-cycle pulse to the granted requester when its count is latched.
- `done`  out  NUM_REQ: one-cycle pulse to the owner when its burst and gap have finished.
- `busy`  out  1: high whenever the state is not IDLE.
- `owner`  out  $clog2(NUM_REQ): index of the current or last owner.
- `led`  out  1: LED drive, active high.

## Operation
- Reset values: `led`=0, `ack`=0, `done`=0, `busy`=0, `owner`=0, state IDLE, tick counter 0, `last`=NUM_REQ-1. Because `last` resets to NUM_REQ-1, requester 0 wins first after reset.
- Tick divider:
  - Counter runs 0..P-1. `tick` is high when the counter equals P-1, then the counter wraps to 0.
  - Counter width is $clog2(P).
  - The counter is forced to 0 on every grant, so the first phase is exactly P cycles.
- Arbitration:
  - Happens in IDLE only.
  - Search starts at `last`+1 modulo NUM_REQ; the first asserted `req` wins.
  - On the grant edge the block registers `owner`, `last`, and `remaining` = cnt[owner]. It also pulses `ack[owner]` and sets `busy`.
- States:
  - IDLE: if any `req` is high, grant. Go to ON with `led`=1 if the latched count is nonzero, otherwise to GAP with `led`=0. If no `req`, stay in IDLE.
  - ON: on `tick`, go to OFF, set `led`=0, decrement `remaining`.
  - OFF: on `tick`, go to ON with `led`=1 if `remaining`≠0. Otherwise go to GAP, or to IDLE with a `done` pulse if GAP_TICKS=0.
  - GAP: count ticks; on the GAP_TICKS-th tick go to IDLE and pulse `done[owner]`.
- `req` is sampled only at arbitration.
  - Deasserting `req` mid-burst does not abort the burst.
  - Changing `cnt` after the grant has no effect.
- A requester that holds `req` after `done` is re-arbitrated. Round-robin serves the other pending requesters before it again.
- Asynchronous reset mid-burst forces all outputs to their reset values immediately; no `done` is issued.

## Timing
- Let `ack` be high in cycle A; the grant decision is made from `req` sampled in cycle A-1.
- `led` is high in cycles A .. A+P-1, low in A+P .. A+2P-1, and the pattern repeats for N blinks.
- `done` is high in exactly one cycle, A + (2N+GAP_TICKS)*P - 1, with the state already IDLE and `busy`=0 in that cycle.
- The earliest next `ack` is the cycle after `done`.
- For N=0, `led` stays 0 and `done` occurs at A + GAP_TICKS*P - 1. If GAP_TICKS is also 0, `done` fires in cycle A together with `ack`.
- `ack` and `done` never assert for more than one bit, or for more than one cycle each.

## Structure
- Shared package `led_pkg`: state enum (IDLE, ON, OFF, GAP) and the function computing P from CLK_FREQ/BLINK_FREQ.
- Sub-module `led_tick_gen` (params CLK_FREQ, BLINK_FREQ; ports clk, rst_n, clear, tick). It holds the divider and is reusable by other LED blocks.
- Arbiter and sequencer FSM live in the top module.

## Test plan
Use CLK_FREQ=8, BLINK_FREQ=1 (P=4), NUM_REQ=3, GAP_TICKS=2.
- Reset, then hold req=3'b001 with cnt0=2:
  - `ack[0]` in cycle A.
  - `led` is 1 in A..A+3 and A+8..A+11, 0 otherwise.
  - `done[0]` in A+23.
  - `busy` falls in A+23.
- req=3'b111 held, all counts 1:
  - grants arrive in order 0, 1, 2, 0.
  - each `ack` comes one cycle after the previous `done`.
  - `owner` matches each grant.
- cnt1=0 with req=3'b010: `ack[1]` in A, `led` never rises, `done[1]` in A+7.
- Deassert `req[0]` and change cnt0 to 7 two cycles after `ack[0]` (cnt0 originally 1): exactly one blink occurs and `done[0]` still pulses.
- Assert `rst_n`=0 in the middle of an ON phase:
  - `led` goes to 0 asynchronously, with no `done`.
  - after release, requester 0 wins first again.
